sensor_scheduler: RTL and testbench
===================================

Name: sensor_scheduler

Overview:
- Sequences the SR04 ultrasonic and DHT11 humidity sensors while the top-level mode FSM sits in a sensor mode (mode 6 = SR04, mode 7 = DHT11).
- Issues start pulses to the selected sensor, waits for its done signal or a timeout, and enforces each sensor's minimum re-trigger interval.
- Supports periodic auto-measurement or manual single triggers (button or UART) and keeps sample/error counters.
- Sits beside the mode FSM in the top level, between the UART RX/button inputs and the two sensor controllers.

Parameters:
- TICK_DIV, 100_000: clk cycles per 1 ms tick.
- SR04_PERIOD_MS, 100: SR04 hold-off between measurements, in ms.
- DHT_PERIOD_MS, 2000: DHT11 hold-off between measurements, in ms.
- SR04_TIMEOUT_MS, 30: maximum SR04 wait for done, in ms.
- DHT_TIMEOUT_MS, 25: maximum DHT11 wait for done, in ms.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-low reset: the block resets on a clk edge where rst==0
- mode  input  3  current top-level mode; 6 = SR04, 7 = DHT11, all other values are non-sensor modes
- rx_data  input  8  UART RX byte
- tx_empty  input  1  low = rx_data holds a valid byte
- btn_trig  input  1  debounced single-cycle manual trigger
- sr_start  output  1  1-cycle start pulse to the SR04 controller
- sr_done  input  1  SR04 measurement complete (pulse)
- dht_start  output  1  1-cycle start pulse to the DHT11 controller
- dht_done  input  1  DHT11 measurement complete (pulse)
- busy  output  1  measurement in flight
- meas_valid  output  1  1-cycle pulse on successful completion
- timeout  output  1  sticky flag: the last measurement timed out
- auto_en  output  1  auto-measure enabled
- sample_cnt  output  8  count of successful measurements
- err_cnt  output  8  count of timeouts

Behaviour:
- Reset values:
  - State IDLE; prescaler 0.
  - All pulses 0; busy 0; timeout 0.
  - auto_en 1; sample_cnt 0; err_cnt 0; pending 0.
- UART commands:
  - cmd_v = ~tx_empty. A command acts once, on the cycle cmd_v rises (registered edge detect); a level held high acts only once.
  - 'G' (8'h47) is a manual trigger.
  - 'A' (8'h41) toggles auto_en.
  - All other bytes, including 'M', are ignored.
- Manual trigger: btn_trig or the 'G' command sets pending. pending is cleared when START is entered.
- Target sensor: tgt = (mode==7). It is latched on entering START.
- ms tick: the prescaler restarts at 0 on entry to WAIT and HOLDOFF. A tick fires when the prescaler reaches TICK_DIV-1; the ms counter increments on each tick.
- State IDLE:
  - If mode is 6 or 7 and (auto_en or pending), go to START.
  - Otherwise stay.
- State START (exactly 1 cycle):
  - Assert sr_start if tgt==0, otherwise dht_start.
  - busy=1.
  - Go to WAIT.
- State WAIT (busy=1):
  - Done of the target sensor:
    - meas_valid pulses in the next cycle.
    - sample_cnt+1, wrapping 255 to 0.
    - timeout is cleared.
    - Go to HOLDOFF.
  - ms count reaches the target sensor's TIMEOUT:
    - timeout=1.
    - err_cnt+1, saturating at 255.
    - Go to HOLDOFF.
  - Done and timeout in the same cycle: done wins.
  - A done from the non-target sensor is ignored.
- State HOLDOFF (busy=0):
  - Lasts exactly PERIOD×TICK_DIV cycles for the target sensor.
  - On expiry: if auto_en or pending, go to START; otherwise go to IDLE.
  - A trigger during HOLDOFF only sets pending; it never shortens the hold-off.
- Abort: in any state, if mode leaves {6,7} or differs from the latched tgt:
  - Go to IDLE next cycle.
  - busy=0; no counter or flag change; pending is kept.
- Triggers in START/WAIT set pending; that pending is served after the following hold-off.
- Trigger and 'A' on the same cycle: both take effect.
- Reset mid-measurement: immediate return to reset values; no start pulse is emitted in the reset cycle.

Decomposition:
- Package sensor_sched_pkg holds:
  - the state enum (IDLE, START, WAIT, HOLDOFF);
  - the mode codes MODE_SR04=3'd6 and MODE_DHT11=3'd7;
  - the ASCII constants CMD_GO=8'h47 and CMD_AUTO=8'h41.
- One sub-module, ms_tick_gen: a TICK_DIV prescaler with a synchronous restart input and a 1-cycle tick output.

Test Plan (TICK_DIV=10, SR04_PERIOD_MS=4, DHT_PERIOD_MS=8, SR04_TIMEOUT_MS=3, DHT_TIMEOUT_MS=5):
- Auto SR04 cycle:
  - Stimulus: release rst with mode=6; sr_done pulses 12 cycles after sr_start.
  - Required response:
    - sr_start pulses 1 cycle after IDLE sees mode=6.
    - meas_valid 1 cycle after done; sample_cnt=1.
    - Next sr_start exactly 40 cycles after HOLDOFF entry.
- DHT11 timeout:
  - Stimulus: mode=7, dht_done never asserted.
  - Required response: 50 cycles after WAIT entry, timeout=1 and err_cnt=1; then an 80-cycle hold-off, then dht_start again.
- Manual mode:
  - Stimulus: 'A' with tx_empty low for 5 cycles (auto_en→0), then btn_trig in IDLE with mode=6.
  - Required response: exactly one sr_start and no repeat after the hold-off. A 'G' inside the hold-off yields a start at hold-off expiry.
- Abort:
  - Stimulus: during SR04 WAIT, mode→2.
  - Required response: IDLE next cycle; busy=0; counters unchanged; a later sr_done is ignored.
- Done/timeout race:
  - Stimulus: sr_done on the cycle the 3 ms timeout expires.
  - Required response: sample_cnt+1, err_cnt unchanged, timeout=0.
- Counter boundaries:
  - Stimulus: 256 successful measurements; 260 timeouts.
  - Required response: sample_cnt wraps to 0; err_cnt holds at 255.

Source files
------------

// File: rtl/sensor_sched_pkg.sv
// Shared definitions for the sensor scheduler: FSM states, top-level mode
// codes for the two sensor modes, and the UART command bytes.
package sensor_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    HOLDOFF = 2'd3
  } sched_state_t;

  localparam logic [2:0] MODE_SR04  = 3'd6;
  localparam logic [2:0] MODE_DHT11 = 3'd7;

  localparam logic [7:0] CMD_GO   = 8'h47;  // 'G' : manual trigger
  localparam logic [7:0] CMD_AUTO = 8'h41;  // 'A' : toggle auto-measure

endpackage

// File: rtl/sensor_scheduler_ms_tick_gen.sv
// ms_tick_gen: divides clk by TICK_DIV into a 1-cycle tick.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-low reset
//   restart - forces the prescaler back to 0 on the next edge
//   tick    - high for the one cycle where the prescaler sits at TICK_DIV-1
module ms_tick_gen #(
  parameter int TICK_DIV = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  // Kept independent of restart: the owner's restart depends on tick.
  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst)                cnt <= '0;
    else if (restart || tick) cnt <= '0;
    else                     cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/sensor_scheduler.sv
// sensor_scheduler: sequences the SR04 (mode 6) and DHT11 (mode 7) sensor
// controllers. Issues a start pulse, waits for done or timeout, then holds
// off for the sensor's re-trigger interval. Auto mode re-arms continuously;
// manual triggers (button or UART 'G') are queued in a pending flag.
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   mode                - top-level mode (6/7 select a sensor)
//   rx_data, tx_empty   - UART byte, valid while tx_empty is low
//   btn_trig            - single-cycle manual trigger
//   sr_start/sr_done    - SR04 controller handshake
//   dht_start/dht_done  - DHT11 controller handshake
//   busy                - measurement in flight (START/WAIT)
//   meas_valid          - 1-cycle pulse after a successful measurement
//   timeout             - sticky: last measurement timed out
//   auto_en             - auto-measure enabled
//   sample_cnt, err_cnt - successes (wrapping) / timeouts (saturating)
module sensor_scheduler
  import sensor_sched_pkg::*;
#(
  parameter int TICK_DIV        = 100_000,
  parameter int SR04_PERIOD_MS  = 100,
  parameter int DHT_PERIOD_MS   = 2000,
  parameter int SR04_TIMEOUT_MS = 30,
  parameter int DHT_TIMEOUT_MS  = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode,
  input  logic [7:0] rx_data,
  input  logic       tx_empty,
  input  logic       btn_trig,
  output logic       sr_start,
  input  logic       sr_done,
  output logic       dht_start,
  input  logic       dht_done,
  output logic       busy,
  output logic       meas_valid,
  output logic       timeout,
  output logic       auto_en,
  output logic [7:0] sample_cnt,
  output logic [7:0] err_cnt
);

  localparam logic [15:0] SR_TMO_LAST  = 16'(SR04_TIMEOUT_MS - 1);
  localparam logic [15:0] DHT_TMO_LAST = 16'(DHT_TIMEOUT_MS - 1);
  localparam logic [15:0] SR_PER_LAST  = 16'(SR04_PERIOD_MS - 1);
  localparam logic [15:0] DHT_PER_LAST = 16'(DHT_PERIOD_MS - 1);

  sched_state_t state;
  logic         tgt;       // latched target: 0 = SR04, 1 = DHT11
  logic         pending;
  logic         cmd_q;
  logic [15:0]  ms_cnt;
  logic         tick;

  logic in_sensor, mode_tgt, abort;
  logic cmd_rise, go_cmd, auto_cmd, trig;
  logic done_tgt, tmo_hit, hold_exp, restart;
  logic [15:0] tmo_last, per_last;

  assign in_sensor = (mode == MODE_SR04) || (mode == MODE_DHT11);
  assign mode_tgt  = (mode == MODE_DHT11);
  // Leaving the sensor modes, or switching sensor mid-sequence, aborts.
  assign abort     = !in_sensor || ((state != IDLE) && (mode_tgt != tgt));

  // UART command acts once per rising edge of the valid level.
  assign cmd_rise = ~tx_empty & ~cmd_q;
  assign go_cmd   = cmd_rise && (rx_data == CMD_GO);
  assign auto_cmd = cmd_rise && (rx_data == CMD_AUTO);
  assign trig     = btn_trig | go_cmd;

  assign done_tgt = tgt ? dht_done : sr_done;
  assign tmo_last = tgt ? DHT_TMO_LAST : SR_TMO_LAST;
  assign per_last = tgt ? DHT_PER_LAST : SR_PER_LAST;

  // Timeout / hold-off end on the tick that completes the final ms, so
  // WAIT spans TIMEOUT*TICK_DIV cycles and HOLDOFF PERIOD*TICK_DIV cycles.
  assign tmo_hit  = (state == WAIT)    && tick && (ms_cnt == tmo_last);
  assign hold_exp = (state == HOLDOFF) && tick && (ms_cnt == per_last);

  // Prescaler and ms counter sit at 0 on the first cycle of WAIT/HOLDOFF.
  assign restart = (state == IDLE) || (state == START) ||
                   ((state == WAIT) && (done_tgt || tmo_hit));

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst)         ms_cnt <= '0;
    else if (restart) ms_cnt <= '0;
    else if (tick)    ms_cnt <= ms_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tgt        <= 1'b0;
      pending    <= 1'b0;
      cmd_q      <= 1'b0;
      sr_start   <= 1'b0;
      dht_start  <= 1'b0;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      auto_en    <= 1'b1;
      sample_cnt <= 8'd0;
      err_cnt    <= 8'd0;
    end else begin
      cmd_q      <= ~tx_empty;
      sr_start   <= 1'b0;
      dht_start  <= 1'b0;
      meas_valid <= 1'b0;
      if (auto_cmd) auto_en <= ~auto_en;
      if (trig)     pending <= 1'b1;

      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE, HOLDOFF: begin
            // IDLE only gets here with a sensor mode selected.
            if (state == IDLE || hold_exp) begin
              if (auto_en || pending) begin
                state     <= START;
                tgt       <= mode_tgt;
                sr_start  <= ~mode_tgt;
                dht_start <= mode_tgt;
                busy      <= 1'b1;
                pending   <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end
          end
          START: state <= WAIT;
          WAIT: begin
            if (done_tgt) begin
              state      <= HOLDOFF;
              busy       <= 1'b0;
              meas_valid <= 1'b1;
              timeout    <= 1'b0;
              sample_cnt <= sample_cnt + 8'd1;
            end else if (tmo_hit) begin
              state   <= HOLDOFF;
              busy    <= 1'b0;
              timeout <= 1'b1;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sensor_scheduler.sv
// Directed bench for sensor_scheduler with a small timing configuration:
// 10 clk/ms, SR04 hold-off 4 ms / timeout 3 ms, DHT11 hold-off 8 ms /
// timeout 5 ms. Outputs are sampled 1 time unit after each rising edge.
module tb_sensor_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] mode = 3'd6;
  logic [7:0] rx_data = 8'h00;
  logic       tx_empty = 1'b1;
  logic       btn_trig = 1'b0;
  logic       sr_done = 1'b0;
  logic       dht_done = 1'b0;
  logic       sr_start, dht_start, busy, meas_valid, timeout, auto_en;
  logic [7:0] sample_cnt, err_cnt;

  int total = 0;
  int bad   = 0;

  sensor_scheduler #(
    .TICK_DIV(10), .SR04_PERIOD_MS(4), .DHT_PERIOD_MS(8),
    .SR04_TIMEOUT_MS(3), .DHT_TIMEOUT_MS(5)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .rx_data(rx_data), .tx_empty(tx_empty),
    .btn_trig(btn_trig), .sr_start(sr_start), .sr_done(sr_done),
    .dht_start(dht_start), .dht_done(dht_done), .busy(busy),
    .meas_valid(meas_valid), .timeout(timeout), .auto_en(auto_en),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Steps k cycles, counting start pulses of either sensor.
  task automatic run_nostart(input int k, output int c);
    c = 0;
    repeat (k) begin
      step(1);
      if (sr_start || dht_start) c++;
    end
  endtask

  // Steps until the selected start pulse is seen, at most 'limit' cycles.
  task automatic wait_start(input bit sel, input int limit, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      step(1);
      if (sel ? dht_start : sr_start) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic send_cmd(input logic [7:0] b, input int cycles);
    rx_data = b; tx_empty = 1'b0; step(cycles); tx_empty = 1'b1;
  endtask

  initial begin
    int n, n1, n2, n3;

    // Reset state
    step(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tmo", 32'(timeout), 0);
    chk("rst_auto", 32'(auto_en), 1);
    chk("rst_samp", 32'(sample_cnt), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_start", 32'(sr_start), 0);

    // Auto SR04 cycle
    rst = 1'b1; step(1);
    chk("t1_start", 32'(sr_start), 1);
    chk("t1_busy", 32'(busy), 1);
    step(12); sr_done = 1'b1; step(1); sr_done = 1'b0;
    chk("t1_valid", 32'(meas_valid), 1);
    chk("t1_samp", 32'(sample_cnt), 1);
    chk("t1_busy_hold", 32'(busy), 0);
    step(1);
    chk("t1_valid_pulse", 32'(meas_valid), 0);
    run_nostart(38, n);
    chk("t1_early", 32'(n), 0);
    step(1);
    chk("t1_restart", 32'(sr_start), 1);

    // DHT11 timeout
    mode = 3'd7;
    wait_start(1'b1, 10, "t2_dstart");
    step(50);
    chk("t2_tmo_early", 32'(timeout), 0);
    chk("t2_busy", 32'(busy), 1);
    step(1);
    chk("t2_tmo", 32'(timeout), 1);
    chk("t2_err", 32'(err_cnt), 1);
    chk("t2_samp", 32'(sample_cnt), 1);
    run_nostart(79, n);
    chk("t2_early", 32'(n), 0);
    step(1);
    chk("t2_restart", 32'(dht_start), 1);

    // Abort during SR04 WAIT
    mode = 3'd6;
    wait_start(1'b0, 10, "t3_sstart");
    step(6); mode = 3'd2; step(1);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_samp", 32'(sample_cnt), 1);
    chk("t3_err", 32'(err_cnt), 1);
    chk("t3_tmo", 32'(timeout), 1);
    sr_done = 1'b1; step(1); sr_done = 1'b0;
    chk("t3_ign", 32'(meas_valid), 0);
    step(1);
    chk("t3_samp2", 32'(sample_cnt), 1);
    run_nostart(30, n);
    chk("t3_idle", 32'(n), 0);

    // Manual mode
    send_cmd(8'h41, 5); step(1);
    chk("t4_auto", 32'(auto_en), 0);
    mode = 3'd6;
    run_nostart(5, n);
    chk("t4_idle", 32'(n), 0);
    btn_trig = 1'b1; step(1); btn_trig = 1'b0; step(1);
    chk("t4_start", 32'(sr_start), 1);
    step(2); sr_done = 1'b1; step(1); sr_done = 1'b0;
    chk("t4_valid", 32'(meas_valid), 1);
    chk("t4_samp", 32'(sample_cnt), 2);
    chk("t4_tmo", 32'(timeout), 0);
    run_nostart(5, n1);
    rx_data = 8'h47; tx_empty = 1'b0;
    run_nostart(3, n2);
    tx_empty = 1'b1;
    run_nostart(31, n3);
    chk("t4_hold", 32'(n1 + n2 + n3), 0);
    step(1);
    chk("t4_gstart", 32'(sr_start), 1);
    step(30);
    chk("t4_tmo_early", 32'(timeout), 0);
    step(1);
    chk("t4_tmo", 32'(timeout), 1);
    chk("t4_err", 32'(err_cnt), 2);
    run_nostart(60, n);
    chk("t4_norepeat", 32'(n), 0);
    chk("t4_busy", 32'(busy), 0);

    // Done/timeout race, plus non-target done ignored
    btn_trig = 1'b1; step(1); btn_trig = 1'b0; step(1);
    chk("t5_start", 32'(sr_start), 1);
    step(4); dht_done = 1'b1; step(1); dht_done = 1'b0;
    chk("t5_xdone", 32'(meas_valid), 0);
    chk("t5_busy", 32'(busy), 1);
    step(25); sr_done = 1'b1; step(1); sr_done = 1'b0;
    chk("t5_valid", 32'(meas_valid), 1);
    chk("t5_samp", 32'(sample_cnt), 3);
    chk("t5_err", 32'(err_cnt), 2);
    chk("t5_tmo", 32'(timeout), 0);

    // Counter boundaries: sample_cnt wraps
    send_cmd(8'h41, 2);
    for (int i = 0; i < 253; i++) begin
      wait_start(1'b0, 100, "t6_sstart");
      step(1); sr_done = 1'b1; step(1); sr_done = 1'b0;
      if (i == 251) chk("t6_samp255", 32'(sample_cnt), 255);
    end
    chk("t6_wrap", 32'(sample_cnt), 0);
    chk("t6_wrap_valid", 32'(meas_valid), 1);

    // err_cnt saturates (258 more timeouts => 260 total)
    for (int i = 0; i < 258; i++) begin
      wait_start(1'b0, 100, "t7_sstart");
      step(31);
      if (i == 252) chk("t7_err255", 32'(err_cnt), 255);
    end
    chk("t7_sat", 32'(err_cnt), 255);
    chk("t7_tmo", 32'(timeout), 1);
    chk("t7_samp", 32'(sample_cnt), 0);

    // Reset mid-measurement
    sample_cnt_nonzero: begin
      wait_start(1'b0, 100, "t8_sstart");
      step(1); sr_done = 1'b1; step(1); sr_done = 1'b0;
      chk("t8_samp", 32'(sample_cnt), 1);
    end
    wait_start(1'b0, 100, "t8_sstart2");
    step(3); rst = 1'b0; step(1);
    chk("t8_busy", 32'(busy), 0);
    chk("t8_samp0", 32'(sample_cnt), 0);
    chk("t8_err0", 32'(err_cnt), 0);
    chk("t8_tmo0", 32'(timeout), 0);
    chk("t8_auto", 32'(auto_en), 1);
    chk("t8_nostart", 32'(sr_start), 0);
    step(1);
    chk("t8_nostart2", 32'(sr_start), 0);
    rst = 1'b1; step(1);
    chk("t8_start", 32'(sr_start), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
